// File: rtl/alu_pkg.sv
// Shared definitions for the ALU with multi-cycle multiply/divide:
// op codes, FSM state encoding and small decode helpers.
package alu_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] ALU_ADD   = 5'd0;
    localparam logic [OP_W-1:0] ALU_SUB   = 5'd1;
    localparam logic [OP_W-1:0] ALU_AND   = 5'd2;
    localparam logic [OP_W-1:0] ALU_OR    = 5'd3;
    localparam logic [OP_W-1:0] ALU_XOR   = 5'd4;
    localparam logic [OP_W-1:0] ALU_NOR   = 5'd5;
    localparam logic [OP_W-1:0] ALU_SLL   = 5'd6;
    localparam logic [OP_W-1:0] ALU_SRL   = 5'd7;
    localparam logic [OP_W-1:0] ALU_SRA   = 5'd8;
    localparam logic [OP_W-1:0] ALU_SLT   = 5'd9;
    localparam logic [OP_W-1:0] ALU_SLTU  = 5'd10;
    localparam logic [OP_W-1:0] ALU_MULT  = 5'd11;
    localparam logic [OP_W-1:0] ALU_MULTU = 5'd12;
    localparam logic [OP_W-1:0] ALU_DIV   = 5'd13;
    localparam logic [OP_W-1:0] ALU_DIVU  = 5'd14;
    localparam logic [OP_W-1:0] ALU_MFHI  = 5'd15;
    localparam logic [OP_W-1:0] ALU_MFLO  = 5'd16;
    localparam logic [OP_W-1:0] ALU_MTHI  = 5'd17;
    localparam logic [OP_W-1:0] ALU_MTLO  = 5'd18;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return (op >= ALU_MULT) && (op <= ALU_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide engine owning the architectural HI/LO registers.
// Optional build macro ALU_MUL_FAST_EN: multiply in one FIX cycle with a hardware multiplier.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             wr_hi,
    input  logic             wr_lo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               is_div_q, is_div_d;
    logic               neg_q_q, neg_q_d;
    logic               neg_r_q, neg_r_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   low_q, low_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               signed_op_s, div_op_s, a_neg_s, b_neg_s;
    logic [WIDTH-1:0]   a_mag_s, b_mag_s;
    logic [WIDTH:0]     sum_s, shifted_s, diff_s, step_s;
    logic [2*WIDTH-1:0] prod_s, prod_fix_s;
`ifdef ALU_MUL_FAST_EN
    logic [2*WIDTH-1:0] fa_s, fb_s;
`endif

    // Next-state, datapath step and sign fix-up for the mult/div engine
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        is_div_d = is_div_q;
        neg_q_d  = neg_q_q;
        neg_r_d  = neg_r_q;
        acc_d    = acc_q;
        low_d    = low_q;
        opnd_d   = opnd_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        signed_op_s = (op == ALU_MULT) || (op == ALU_DIV);
        div_op_s    = (op == ALU_DIV) || (op == ALU_DIVU);
        a_neg_s     = signed_op_s & a[WIDTH-1];
        b_neg_s     = signed_op_s & b[WIDTH-1];
        a_mag_s     = a_neg_s ? -a : a;
        b_mag_s     = b_neg_s ? -b : b;

        sum_s     = {1'b0, acc_q} + {1'b0, opnd_q};
        shifted_s = {acc_q, low_q[WIDTH-1]};
        diff_s    = shifted_s - {1'b0, opnd_q};
        step_s    = low_q[0] ? sum_s : {1'b0, acc_q};

`ifdef ALU_MUL_FAST_EN
        fa_s   = {{WIDTH{1'b0}}, opnd_q};
        fb_s   = {{WIDTH{1'b0}}, low_q};
        prod_s = fa_s * fb_s;
`else
        prod_s = {acc_q, low_q};
`endif
        prod_fix_s = neg_q_q ? -prod_s : prod_s;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_div_d = div_op_s;
                    count_d  = CNT_W'(WIDTH);
                    acc_d    = {WIDTH{1'b0}};
                    neg_q_d  = a_neg_s ^ b_neg_s;
                    neg_r_d  = div_op_s & a_neg_s;
                    opnd_d   = div_op_s ? b_mag_s : a_mag_s;
                    low_d    = div_op_s ? a_mag_s : b_mag_s;
                    state_d  = S_RUN;
                    // Divide by zero bypasses the iteration: hi takes raw a, lo all ones
                    if (div_op_s && (b == {WIDTH{1'b0}})) begin
                        acc_d   = a;
                        low_d   = {WIDTH{1'b1}};
                        neg_q_d = 1'b0;
                        neg_r_d = 1'b0;
                        state_d = S_FIX;
                    end else begin
`ifdef ALU_MUL_FAST_EN
                        state_d = div_op_s ? S_RUN : S_FIX;
`else
                        state_d = S_RUN;
`endif
                    end
                end else if (wr_hi) begin
                    hi_d = a;
                end else if (wr_lo) begin
                    lo_d = a;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (is_div_q) begin
                    if (!diff_s[WIDTH]) begin
                        acc_d = diff_s[WIDTH-1:0];
                        low_d = {low_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = shifted_s[WIDTH-1:0];
                        low_d = {low_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = step_s[WIDTH:1];
                    low_d = {step_s[0], low_q[WIDTH-1:1]};
                end
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d = S_FIX;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_FIX: begin
                if (is_div_q) begin
                    hi_d = neg_r_q ? -acc_q : acc_q;
                    lo_d = neg_q_q ? -low_q : low_q;
                end else begin
                    hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix_s[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and architectural register update with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            count_q  <= {CNT_W{1'b0}};
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            acc_q    <= {WIDTH{1'b0}};
            low_q    <= {WIDTH{1'b0}};
            opnd_q   <= {WIDTH{1'b0}};
            hi_q     <= {WIDTH{1'b0}};
            lo_q     <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            is_div_q <= is_div_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            acc_q    <= acc_d;
            low_q    <= low_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/alu_muldiv.sv
// EX-stage integer ALU: single-cycle ops plus HI/LO access, with mult/div delegated to muldiv_iter.
// Optional build macro ALU_MUL_FAST_EN selects the single-cycle multiplier inside muldiv_iter.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sign,
    output logic [WIDTH-1:0] out,
    output logic             overflow,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic             accept_s;
    logic [WIDTH-1:0] out_s;
    logic [SHAMT_W-1:0] shamt_s;

    assign accept_s = in_valid & ~busy;
    assign shamt_s  = a[SHAMT_W-1:0];

    muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .reset (reset),
        .start (accept_s & is_muldiv(op)),
        .op    (op),
        .a     (a),
        .b     (b),
        .wr_hi (accept_s & (op == ALU_MTHI)),
        .wr_lo (accept_s & (op == ALU_MTLO)),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Combinational result mux for single-cycle and HI/LO read ops
    always_comb begin
        out_s = {WIDTH{1'b0}};
        case (op)
            ALU_ADD:  out_s = a + b;
            ALU_SUB:  out_s = a - b;
            ALU_AND:  out_s = a & b;
            ALU_OR:   out_s = a | b;
            ALU_XOR:  out_s = a ^ b;
            ALU_NOR:  out_s = ~(a | b);
            ALU_SLL:  out_s = b << shamt_s;
            ALU_SRL:  out_s = b >> shamt_s;
            ALU_SRA:  out_s = $signed(b) >>> shamt_s;
            ALU_SLT:  out_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: out_s = {{(WIDTH-1){1'b0}}, (a < b)};
            ALU_MFHI: out_s = hi;
            ALU_MFLO: out_s = lo;
            default:  out_s = {WIDTH{1'b0}};
        endcase
    end

    assign out = out_s;
    assign overflow = sign & (((op == ALU_ADD) & (a[WIDTH-1] == b[WIDTH-1]) & (out_s[WIDTH-1] != a[WIDTH-1]))
                            | ((op == ALU_SUB) & (a[WIDTH-1] != b[WIDTH-1]) & (out_s[WIDTH-1] != a[WIDTH-1])));

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: directed plan cases plus randomized ops vs an arithmetic model.
module tb_alu_muldiv;
    import alu_pkg::*;

    localparam int W = 32;
`ifdef ALU_MUL_FAST_EN
    localparam int MUL_CYC = 1;
`else
    localparam int MUL_CYC = W + 1;
`endif
    localparam int DIV_CYC = W + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [4:0]    op = 5'd0;
    logic [W-1:0]  a = 32'd0;
    logic [W-1:0]  b = 32'd0;
    logic          sign = 1'b0;
    logic [W-1:0]  out, hi, lo;
    logic          overflow, busy, done;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] m_hi = 32'd0;
    logic [W-1:0] m_lo = 32'd0;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .op(op), .a(a), .b(b),
        .sign(sign), .out(out), .overflow(overflow), .busy(busy), .done(done),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] ref_out(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        int     sh = int'(x % 32'd32);
        case (o)
            5'd0:  return W'(sx + sy);
            5'd1:  return W'(sx - sy);
            5'd2:  return x & y;
            5'd3:  return x | y;
            5'd4:  return x ^ y;
            5'd5:  return ~(x | y);
            5'd6:  return W'(longint'(y) * (longint'(1) << sh));
            5'd7:  return W'(longint'(y) / (longint'(1) << sh));
            5'd8:  return W'((sy - ((sy % (longint'(1) << sh) + (longint'(1) << sh)) % (longint'(1) << sh))) / (longint'(1) << sh));
            5'd9:  return (sx < sy) ? 32'd1 : 32'd0;
            5'd10: return (x < y) ? 32'd1 : 32'd0;
            5'd15: return m_hi;
            5'd16: return m_lo;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_ovf(input logic [4:0] o, input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        longint r;
        if (!s || (o > 5'd1)) return 1'b0;
        r = (o == 5'd0) ? longint'($signed(x)) + longint'($signed(y)) : longint'($signed(x)) - longint'($signed(y));
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    function automatic logic [2*W-1:0] ref_md(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        logic [63:0] ux = {32'd0, x};
        logic [63:0] uy = {32'd0, y};
        case (o)
            5'd11: return 64'(sx * sy);
            5'd12: return ux * uy;
            5'd13: return (y == 32'd0) ? {x, 32'hFFFF_FFFF} : {W'(sx % sy), W'(sx / sy)};
            5'd14: return (y == 32'd0) ? {x, 32'hFFFF_FFFF} : {W'(ux % uy), W'(ux / uy)};
            default: return {m_hi, m_lo};
        endcase
    endfunction

    function automatic int ref_cyc(input logic [4:0] o, input logic [W-1:0] y);
        if ((o == 5'd13 || o == 5'd14) && y == 32'd0) return 1;
        return (o == 5'd11 || o == 5'd12) ? MUL_CYC : DIV_CYC;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_md(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int cyc, output logic dn);
        in_valid = 1'b1; op = o; a = x; b = y;
        tick();
        in_valid = 1'b0; op = 5'd0;
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            tick();
        end
        dn = done;
    endtask

    task automatic test_reset();
        reset = 1'b1; op = ALU_ADD; a = 32'd5; b = 32'd6;
        tick(); tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%0b exp=0", done); end
        n_cmp++; if ({hi, lo} !== 64'd0) begin n_err++; $display("FAIL reset_hilo got=%h exp=0", {hi, lo}); end
        n_cmp++; if (out !== 32'd11) begin n_err++; $display("FAIL reset_out_comb got=%h exp=0000000b", out); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_alu_directed();
        logic [4:0]   ops [6] = '{ALU_ADD, ALU_ADD, ALU_SRA, ALU_SLTU, ALU_SLT, ALU_SUB};
        logic [W-1:0] as  [6] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd4, 32'd1, 32'd1, 32'h8000_0000};
        logic [W-1:0] bs  [6] = '{32'd1, 32'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
        logic         ss  [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [W-1:0] eo  [6] = '{32'h8000_0000, 32'h8000_0000, 32'hF800_0000, 32'd1, 32'd0, 32'h7FFF_FFFF};
        logic         ev  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            op = ops[i]; a = as[i]; b = bs[i]; sign = ss[i];
            #1;
            n_cmp++; if (out !== eo[i]) begin n_err++; $display("FAIL alu_dir%0d_out got=%h exp=%h", i, out, eo[i]); end
            n_cmp++; if (overflow !== ev[i]) begin n_err++; $display("FAIL alu_dir%0d_ovf got=%0b exp=%0b", i, overflow, ev[i]); end
        end
        sign = 1'b0;
    endtask

    task automatic test_alu_random();
        logic [4:0]   o;
        logic [W-1:0] exp_o;
        logic         exp_v;
        for (int i = 0; i < 300; i++) begin
            o = (i % 10 == 9) ? 5'($urandom_range(19, 31)) : ((i % 10 == 8) ? 5'($urandom_range(15, 16)) : 5'($urandom_range(0, 10)));
            a = $urandom(); b = $urandom(); sign = 1'($urandom());
            if (i % 7 == 0) a = {a[W-1], {(W-1){~a[W-1]}}};
            op = o; in_valid = 1'b1;
            exp_o = ref_out(o, a, b);
            exp_v = ref_ovf(o, sign, a, b);
            #1;
            n_cmp++; if (out !== exp_o) begin n_err++; $display("FAIL alu_rand op=%0d a=%h b=%h got=%h exp=%h", o, a, b, out, exp_o); end
            n_cmp++; if (overflow !== exp_v) begin n_err++; $display("FAIL alu_ovf op=%0d a=%h b=%h got=%0b exp=%0b", o, a, b, overflow, exp_v); end
            tick();
            n_cmp++; if ({hi, lo} !== {m_hi, m_lo}) begin n_err++; $display("FAIL alu_nostate op=%0d got=%h exp=%h", o, {hi, lo}, {m_hi, m_lo}); end
        end
        in_valid = 1'b0; sign = 1'b0;
    endtask

    task automatic test_muldiv_directed();
        logic [4:0]   ops [4] = '{ALU_MULT, ALU_DIV, ALU_DIVU, ALU_DIV};
        logic [W-1:0] as  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000};
        logic [W-1:0] bs  [4] = '{32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF};
        logic [2*W-1:0] ex [4] = '{64'hFFFF_FFFF_FFFF_FFEB, 64'hFFFF_FFFF_FFFF_FFFD,
                                   64'h0000_0007_FFFF_FFFF, 64'h0000_0000_8000_0000};
        int   cyc;
        logic dn;
        for (int i = 0; i < 4; i++) begin
            run_md(ops[i], as[i], bs[i], cyc, dn);
            n_cmp++; if (cyc != ref_cyc(ops[i], bs[i])) begin n_err++; $display("FAIL md_dir%0d_busy got=%0d exp=%0d", i, cyc, ref_cyc(ops[i], bs[i])); end
            n_cmp++; if (dn !== 1'b1) begin n_err++; $display("FAIL md_dir%0d_done got=%0b exp=1", i, dn); end
            n_cmp++; if ({hi, lo} !== ex[i]) begin n_err++; $display("FAIL md_dir%0d_hilo got=%h exp=%h", i, {hi, lo}, ex[i]); end
            m_hi = ex[i][2*W-1:W]; m_lo = ex[i][W-1:0];
            tick();
            n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL md_dir%0d_done_pulse got=%0b exp=0", i, done); end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0]     o;
        logic [W-1:0]   x, y;
        logic [2*W-1:0] exp;
        int   cyc;
        logic dn;
        for (int i = 0; i < 24; i++) begin
            o = 5'($urandom_range(11, 14));
            x = $urandom(); y = (i % 6 == 5) ? 32'd0 : $urandom();
            if (i % 4 == 3) y = 32'($urandom_range(1, 300));
            exp = ref_md(o, x, y);
            run_md(o, x, y, cyc, dn);
            n_cmp++; if (cyc != ref_cyc(o, y)) begin n_err++; $display("FAIL b2b_busy op=%0d got=%0d exp=%0d", o, cyc, ref_cyc(o, y)); end
            n_cmp++; if (dn !== 1'b1) begin n_err++; $display("FAIL b2b_done op=%0d got=%0b exp=1", o, dn); end
            n_cmp++; if ({hi, lo} !== exp) begin n_err++; $display("FAIL b2b_hilo op=%0d a=%h b=%h got=%h exp=%h", o, x, y, {hi, lo}, exp); end
            m_hi = exp[2*W-1:W]; m_lo = exp[W-1:0];
            op = ALU_MFHI; #1;
            n_cmp++; if (out !== m_hi) begin n_err++; $display("FAIL b2b_mfhi got=%h exp=%h", out, m_hi); end
            op = ALU_MFLO; #1;
            n_cmp++; if (out !== m_lo) begin n_err++; $display("FAIL b2b_mflo got=%h exp=%h", out, m_lo); end
        end
        op = ALU_ADD;
    endtask

    task automatic test_mthi();
        logic [2*W-1:0] exp;
        int cyc;
        exp = ref_md(ALU_MULTU, 32'd5, 32'd9);
        in_valid = 1'b1; op = ALU_MULTU; a = 32'd5; b = 32'd9;
        tick();
        op = ALU_MTHI; a = 32'h1234;
        tick();
        in_valid = 1'b0; op = ALU_ADD;
        cyc = 0;
        while (busy && cyc < 100) begin cyc++; tick(); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL mthi_busy_timeout got=%0b exp=0", busy); end
        n_cmp++; if (hi !== exp[2*W-1:W]) begin n_err++; $display("FAIL mthi_while_busy got=%h exp=%h", hi, exp[2*W-1:W]); end
        m_hi = exp[2*W-1:W]; m_lo = exp[W-1:0];
        in_valid = 1'b1; op = ALU_MTHI; a = 32'h1234;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (hi !== 32'h1234) begin n_err++; $display("FAIL mthi_idle got=%h exp=00001234", hi); end
        m_hi = 32'h1234;
        in_valid = 1'b1; op = ALU_MTLO; a = 32'hCAFE_0001;
        tick();
        in_valid = 1'b0;
        n_cmp++; if ({hi, lo} !== 64'h0000_1234_CAFE_0001) begin n_err++; $display("FAIL mtlo_idle got=%h exp=00001234cafe0001", {hi, lo}); end
        m_lo = 32'hCAFE_0001;
    endtask

    task automatic test_reset_mid();
        logic [2*W-1:0] exp;
        int cyc;
        in_valid = 1'b1; op = ALU_DIVU; a = 32'hFFFF_0000; b = 32'd3;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_busy got=%0b exp=1", busy); end
        reset = 1'b1;
        tick();
        n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL rstmid_flags got=%b exp=00", {busy, done}); end
        n_cmp++; if ({hi, lo} !== 64'd0) begin n_err++; $display("FAIL rstmid_hilo got=%h exp=0", {hi, lo}); end
        m_hi = 32'd0; m_lo = 32'd0;
        reset = 1'b0; in_valid = 1'b1; op = ALU_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        exp = ref_md(ALU_MULTU, a, b);
        tick();
        in_valid = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rstmid_accept got=%0b exp=1", busy); end
        cyc = 1;
        tick();
        while (busy && cyc < 100) begin cyc++; tick(); end
        n_cmp++; if (cyc != MUL_CYC) begin n_err++; $display("FAIL rstmid_mul_busy got=%0d exp=%0d", cyc, MUL_CYC); end
        n_cmp++; if ({hi, lo} !== exp) begin n_err++; $display("FAIL rstmid_mul_hilo got=%h exp=%h", {hi, lo}, exp); end
        m_hi = exp[2*W-1:W]; m_lo = exp[W-1:0];
    endtask

    initial begin
        test_reset();
        test_alu_directed();
        test_alu_random();
        test_muldiv_directed();
        test_back_to_back();
        test_mthi();
        test_reset_mid();
        test_alu_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
